refgen: RTL and testbench



---
 rtl/jag_ref_pkg.sv | 21 ++
 rtl/ref_timer.sv | 64 ++++++
 rtl/refgen.sv | 151 +++++++++++++++
 tb/tb_refgen.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jag_ref_pkg.sv
// Shared definitions for the DRAM refresh request generator:
// FSM state encoding and default widths / reset constants.
package jag_ref_pkg;

  // Default width of the refresh interval reload value
  localparam int RATE_W_DEF = 10;

  // Default width of the owed-refresh (debt) counter
  localparam int DEBT_W_DEF = 3;

  // Interval register value after reset
  localparam logic [RATE_W_DEF-1:0] RATE_RST_DEF = 10'h1FF;

  // Request handshake states towards the bus arbiter
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    GAP  = 2'b10
  } state_t;

endpackage

// File: rtl/ref_timer.sv
// Refresh interval timer: counts down from the interval register and
// emits a one-cycle tick every rate+1 enabled cycles. An interval of
// zero disables ticking entirely.
module ref_timer
  import jag_ref_pkg::*;
#(
  parameter int                RATE_W   = RATE_W_DEF,
  parameter logic [RATE_W-1:0] RATE_RST = RATE_RST_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_refen,
  input  logic              i_rateld,
  input  logic [RATE_W-1:0] i_refrate,
  output logic              o_tick
);

  logic [RATE_W-1:0] r_rate;
  logic [RATE_W-1:0] r_cnt;
  logic [RATE_W-1:0] w_cnt_nxt;
  logic              w_cnt_zero;
  logic              w_tick;

  assign w_cnt_zero = (r_cnt == {RATE_W{1'b0}});

  // A tick needs a running timer, an expired count and a nonzero interval
  assign w_tick = i_refen && w_cnt_zero && (r_rate != {RATE_W{1'b0}});

  // Next count: hold when disabled, decrement while nonzero, reload at zero
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (!i_refen) begin
      w_cnt_nxt = r_cnt;
    end else if (!w_cnt_zero) begin
      w_cnt_nxt = r_cnt - RATE_W'(1);
    end else begin
      // With a zero interval this reload keeps the counter parked at 0
      w_cnt_nxt = r_rate;
    end
  end

  // Interval register: loaded by strobe, does not disturb the running count
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rate <= RATE_RST;
    end else if (i_rateld) begin
      r_rate <= i_refrate;
    end else begin
      r_rate <= r_rate;
    end
  end

  // Down-counter state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= RATE_RST;
    end else begin
      r_cnt <= w_cnt_nxt;
    end
  end

  assign o_tick = w_tick;

endmodule

// File: rtl/refgen.sv
// DRAM refresh request generator. Accumulates owed refresh cycles from
// the interval timer, requests the arbiter for each one, retires debt on
// acknowledge, and flags urgency and lost ticks.
module refgen
  import jag_ref_pkg::*;
#(
  parameter int                RATE_W   = RATE_W_DEF,
  parameter int                DEBT_W   = DEBT_W_DEF,
  parameter int                DEBT_MAX = 7,
  parameter int                URG_LVL  = 4,
  parameter logic [RATE_W-1:0] RATE_RST = RATE_RST_DEF
) (
  input  logic              sys_clk,
  input  logic              resetl,
  input  logic              refen,
  input  logic [RATE_W-1:0] refrate,
  input  logic              rateld,
  input  logic              refack,
  output logic              refreq,
  output logic              refurg,
  output logic [DEBT_W-1:0] refdebt,
  output logic              refovf
);

  localparam logic [DEBT_W-1:0] DEBT_MAX_V = DEBT_W'(DEBT_MAX);
  localparam logic [DEBT_W-1:0] URG_LVL_V  = DEBT_W'(URG_LVL);
  localparam logic [DEBT_W-1:0] DEBT_ZERO  = {DEBT_W{1'b0}};
  localparam logic [DEBT_W-1:0] DEBT_ONE   = DEBT_W'(1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [DEBT_W-1:0] r_debt;
  logic [DEBT_W-1:0] w_debt_nxt;
  logic              r_req;
  logic              r_urg;
  logic              r_ovf;
  logic              w_ovf_set;
  logic              w_tick;
  logic              w_ack_ok;

  ref_timer #(
    .RATE_W   (RATE_W),
    .RATE_RST (RATE_RST)
  ) u_timer (
    .i_clk     (sys_clk),
    .i_rst_n   (resetl),
    .i_refen   (refen),
    .i_rateld  (rateld),
    .i_refrate (refrate),
    .o_tick    (w_tick)
  );

  // Acknowledges only count while a request is actually outstanding
  assign w_ack_ok = refack && (r_state == REQ);

  // Debt update: +tick, -ack; saturate at DEBT_MAX and flag the lost tick
  always_comb begin
    w_debt_nxt = r_debt;
    w_ovf_set  = 1'b0;
    case ({w_tick, w_ack_ok})
      2'b10: begin
        if (r_debt == DEBT_MAX_V) begin
          w_ovf_set = 1'b1;
        end else begin
          w_debt_nxt = r_debt + DEBT_ONE;
        end
      end
      2'b01: begin
        if (r_debt != DEBT_ZERO) begin
          w_debt_nxt = r_debt - DEBT_ONE;
        end else begin
          w_debt_nxt = r_debt;
        end
      end
      default: begin
        // Both or neither: net change is zero
        w_debt_nxt = r_debt;
      end
    endcase
  end

  // Handshake FSM next state; GAP forces one low cycle between requests
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (r_debt != DEBT_ZERO) begin
          w_state_nxt = REQ;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      REQ: begin
        if (w_ack_ok) begin
          w_state_nxt = GAP;
        end else begin
          w_state_nxt = REQ;
        end
      end
      GAP: begin
        if (r_debt != DEBT_ZERO) begin
          w_state_nxt = REQ;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // FSM state register and registered request output
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_req   <= (w_state_nxt == REQ);
    end
  end

  // Debt register with urgency registered from the same next value
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      r_debt <= DEBT_ZERO;
      r_urg  <= 1'b0;
    end else begin
      r_debt <= w_debt_nxt;
      r_urg  <= (w_debt_nxt >= URG_LVL_V);
    end
  end

  // Sticky lost-tick flag, cleared only by reset
  always_ff @(posedge sys_clk or negedge resetl) begin
    if (!resetl) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_set) begin
      r_ovf <= 1'b1;
    end else begin
      r_ovf <= r_ovf;
    end
  end

  assign refreq  = r_req;
  assign refurg  = r_urg;
  assign refdebt = r_debt;
  assign refovf  = r_ovf;

endmodule

// File: tb/tb_refgen.sv
// Scoreboard bench for refgen: stimulus pushes the expected sequence of
// output changes (with the cycle each must appear in); a monitor pops one
// entry whenever the DUT outputs change and compares.
module tb_refgen;

  logic       sys_clk;
  logic       resetl;
  logic       refen;
  logic [9:0] refrate;
  logic       rateld;
  logic       refack;
  logic       refreq;
  logic       refurg;
  logic [2:0] refdebt;
  logic       refovf;

  logic       refack_man;
  logic       refack_auto;
  logic       ack_auto;
  logic       mon_on;
  logic       probe_req;
  logic [5:0] probe_exp;

  int cyc = 0;
  int n_vec = 0;
  int n_mis = 0;
  int c0;
  int c1;

  typedef struct {
    int         cyc;
    logic [5:0] vec;   // {refreq, refurg, refovf, refdebt}
  } ev_t;

  ev_t exq[$];

  assign refack = refack_man | refack_auto;

  refgen dut (
    .sys_clk (sys_clk),
    .resetl  (resetl),
    .refen   (refen),
    .refrate (refrate),
    .rateld  (rateld),
    .refack  (refack),
    .refreq  (refreq),
    .refurg  (refurg),
    .refdebt (refdebt),
    .refovf  (refovf)
  );

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  always @(posedge sys_clk) cyc <= cyc + 1;

  // Monitor: every output change must match the head of the queue
  logic [5:0] cur;
  logic [5:0] prev = 6'b0;
  ev_t        e;
  always @(negedge sys_clk) begin
    cur = {refreq, refurg, refovf, refdebt};
    if (mon_on && (cur != prev)) begin
      n_vec++;
      if (exq.size() == 0) begin
        n_mis++;
        $display("FAIL unexpected_change: cyc %0d got req/urg/ovf/debt=%b/%b/%b/%0d, required no change",
                 cyc, cur[5], cur[4], cur[3], cur[2:0]);
      end else begin
        e = exq.pop_front();
        if ((e.cyc != cyc) || (e.vec != cur)) begin
          n_mis++;
          $display("FAIL event: got cyc %0d req/urg/ovf/debt=%b/%b/%b/%0d, required cyc %0d %b/%b/%b/%0d",
                   cyc, cur[5], cur[4], cur[3], cur[2:0],
                   e.cyc, e.vec[5], e.vec[4], e.vec[3], e.vec[2:0]);
        end
      end
    end
    if (probe_req) begin
      n_vec++;
      if ((cur != probe_exp) || (exq.size() != 0)) begin
        n_mis++;
        $display("FAIL probe: cyc %0d got outputs %b with %0d events pending, required %b with 0 pending",
                 cyc, cur, exq.size(), probe_exp);
      end
    end
    prev = cur;
  end

  // Arbiter model: acknowledge two cycles after each refreq rise
  logic prev_rq;
  initial begin
    refack_auto = 1'b0;
    prev_rq     = 1'b0;
    forever begin
      @(posedge sys_clk); #1;
      if (ack_auto && refreq && !prev_rq) begin
        @(posedge sys_clk); #1;
        refack_auto = 1'b1;
        @(posedge sys_clk); #1;
        refack_auto = 1'b0;
      end
      prev_rq = refreq;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic wait_to(input int t);
    while (cyc < t) begin
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic expect_ev(input int c, input logic rq, input logic urg,
                           input logic [2:0] d, input logic ovf);
    ev_t x;
    x.cyc = c;
    x.vec = {rq, urg, ovf, d};
    exq.push_back(x);
  endtask

  task automatic probe(input logic [5:0] v);
    probe_exp = v;
    probe_req = 1'b1;
    @(posedge sys_clk); #1;
    probe_req = 1'b0;
  endtask

  initial begin
    resetl = 1'b0; refen = 1'b0; rateld = 1'b0; refrate = 10'd0;
    refack_man = 1'b0; ack_auto = 1'b0; mon_on = 1'b0;
    probe_req = 1'b0; probe_exp = 6'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    resetl = 1'b1;
    mon_on = 1'b1;
    probe(6'b000000);

    // Test 1: debt accumulation, urgency, saturation and overflow
    c0 = cyc;
    refen = 1'b1; rateld = 1'b1; refrate = 10'd3;
    expect_ev(c0 + 512, 1'b0, 1'b0, 3'd1, 1'b0);
    expect_ev(c0 + 513, 1'b1, 1'b0, 3'd1, 1'b0);
    expect_ev(c0 + 516, 1'b1, 1'b0, 3'd2, 1'b0);
    expect_ev(c0 + 520, 1'b1, 1'b0, 3'd3, 1'b0);
    expect_ev(c0 + 524, 1'b1, 1'b1, 3'd4, 1'b0);
    expect_ev(c0 + 528, 1'b1, 1'b1, 3'd5, 1'b0);
    expect_ev(c0 + 532, 1'b1, 1'b1, 3'd6, 1'b0);
    expect_ev(c0 + 536, 1'b1, 1'b1, 3'd7, 1'b0);
    expect_ev(c0 + 540, 1'b1, 1'b1, 3'd7, 1'b1);
    wait_to(c0 + 1);
    rateld = 1'b0;
    wait_to(c0 + 541);
    resetl = 1'b0; refen = 1'b0;
    expect_ev(c0 + 541, 1'b0, 1'b0, 3'd0, 1'b0);
    wait_to(c0 + 543);
    resetl = 1'b1;
    probe(6'b000000);

    // Test 2: steady REQ/GAP handshake with a responsive arbiter
    c0 = cyc;
    refen = 1'b1; rateld = 1'b1; refrate = 10'd3; ack_auto = 1'b1;
    for (int k = 0; k < 5; k++) begin
      expect_ev(c0 + 512 + 4 * k, 1'b0, 1'b0, 3'd1, 1'b0);
      expect_ev(c0 + 513 + 4 * k, 1'b1, 1'b0, 3'd1, 1'b0);
      expect_ev(c0 + 515 + 4 * k, 1'b0, 1'b0, 3'd0, 1'b0);
    end
    expect_ev(c0 + 532, 1'b0, 1'b0, 3'd1, 1'b0);
    expect_ev(c0 + 533, 1'b1, 1'b0, 3'd1, 1'b0);
    wait_to(c0 + 1);
    rateld = 1'b0;
    wait_to(c0 + 534);
    ack_auto = 1'b0; resetl = 1'b0; refen = 1'b0;
    expect_ev(c0 + 534, 1'b0, 1'b0, 3'd0, 1'b0);
    wait_to(c0 + 538);
    resetl = 1'b1;
    probe(6'b000000);

    // Tests 3/5/4: tick+ack together, rate 0 drain, acks in GAP and IDLE
    c0 = cyc;
    refen = 1'b1; rateld = 1'b1; refrate = 10'd3;
    expect_ev(c0 + 512, 1'b0, 1'b0, 3'd1, 1'b0);
    expect_ev(c0 + 513, 1'b1, 1'b0, 3'd1, 1'b0);
    expect_ev(c0 + 516, 1'b1, 1'b0, 3'd2, 1'b0);
    expect_ev(c0 + 520, 1'b0, 1'b0, 3'd2, 1'b0);
    expect_ev(c0 + 521, 1'b1, 1'b0, 3'd2, 1'b0);
    expect_ev(c0 + 524, 1'b1, 1'b0, 3'd3, 1'b0);
    expect_ev(c0 + 526, 1'b0, 1'b0, 3'd2, 1'b0);
    expect_ev(c0 + 527, 1'b1, 1'b0, 3'd2, 1'b0);
    expect_ev(c0 + 529, 1'b0, 1'b0, 3'd1, 1'b0);
    expect_ev(c0 + 530, 1'b1, 1'b0, 3'd1, 1'b0);
    expect_ev(c0 + 532, 1'b0, 1'b0, 3'd0, 1'b0);
    wait_to(c0 + 1);
    rateld = 1'b0;
    wait_to(c0 + 519);
    refack_man = 1'b1;          // sampled at edge 520 together with a tick
    wait_to(c0 + 520);
    refack_man = 1'b0;
    wait_to(c0 + 524);
    rateld = 1'b1; refrate = 10'd0;
    wait_to(c0 + 525);
    rateld = 1'b0;
    refack_man = 1'b1;          // edge 526 in REQ, edge 527 in GAP (ignored)
    wait_to(c0 + 527);
    refack_man = 1'b0;
    wait_to(c0 + 528);
    refack_man = 1'b1;
    wait_to(c0 + 529);
    refack_man = 1'b0;
    wait_to(c0 + 531);
    refack_man = 1'b1;
    wait_to(c0 + 532);
    refack_man = 1'b0;
    wait_to(c0 + 539);
    refack_man = 1'b1;          // ack in IDLE with zero debt
    wait_to(c0 + 540);
    refack_man = 1'b0;
    wait_to(c0 + 560);
    probe(6'b000000);
    resetl = 1'b0; refen = 1'b0;
    wait_to(cyc + 2);
    resetl = 1'b1;

    // Test 6: asynchronous reset mid-handshake restores the interval
    c0 = cyc;
    refen = 1'b1; rateld = 1'b1; refrate = 10'd3;
    expect_ev(c0 + 512, 1'b0, 1'b0, 3'd1, 1'b0);
    expect_ev(c0 + 513, 1'b1, 1'b0, 3'd1, 1'b0);
    expect_ev(c0 + 516, 1'b1, 1'b0, 3'd2, 1'b0);
    expect_ev(c0 + 520, 1'b1, 1'b0, 3'd3, 1'b0);
    expect_ev(c0 + 524, 1'b1, 1'b1, 3'd4, 1'b0);
    expect_ev(c0 + 528, 1'b1, 1'b1, 3'd5, 1'b0);
    wait_to(c0 + 1);
    rateld = 1'b0;
    wait_to(c0 + 530);
    resetl = 1'b0;
    expect_ev(c0 + 530, 1'b0, 1'b0, 3'd0, 1'b0);
    wait_to(c0 + 532);
    c1 = cyc;
    resetl = 1'b1;              // refen still 1: timer restarts from RATE_RST
    expect_ev(c1 + 512,  1'b0, 1'b0, 3'd1, 1'b0);
    expect_ev(c1 + 513,  1'b1, 1'b0, 3'd1, 1'b0);
    expect_ev(c1 + 1024, 1'b1, 1'b0, 3'd2, 1'b0);
    wait_to(c1 + 1030);
    probe(6'b100010);
    repeat (2) @(posedge sys_clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
